// File: rtl/bid_arb_pkg.sv
// bid_arb_pkg: arbiter state type, default parameter set and saturating refill helper
package bid_arb_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int DEF_N_MASTERS     = 4;
    localparam int DEF_BID_W         = 4;
    localparam int DEF_BAL_W         = 10;
    localparam int DEF_BAL_INIT      = 750;
    localparam int DEF_BAL_MAX       = 900;
    localparam int DEF_REFILL_AMT    = 750;
    localparam int DEF_REFILL_PERIOD = 400;
    localparam int DEF_MAX_HOLD      = 16;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] cap);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, cap}) ? cap : sum[31:0];
    endfunction

endpackage

// File: rtl/credit_account.sv
// credit_account: one master's credit balance with debit and saturating periodic refill
module credit_account
    import bid_arb_pkg::*;
#(
    parameter int BAL_W      = DEF_BAL_W,
    parameter int BAL_INIT   = DEF_BAL_INIT,
    parameter int BAL_MAX    = DEF_BAL_MAX,
    parameter int REFILL_AMT = DEF_REFILL_AMT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             debit_en,
    input  logic [BAL_W-1:0] debit_amt,
    input  logic             refill_pulse,
    output logic [BAL_W-1:0] balance
);

    logic [BAL_W-1:0] debited;

    // debit first so a coincident refill saturates the post-debit value
    assign debited = debit_en ? balance - debit_amt : balance;

    always_ff @(posedge clk) begin
        if (!rst_n)
            balance <= BAL_W'(BAL_INIT);
        else if (refill_pulse)
            balance <= BAL_W'(sat_add(32'(debited), 32'(REFILL_AMT), 32'(BAL_MAX)));
        else
            balance <= debited;
    end

endmodule

// File: rtl/bid_arbiter.sv
// bid_arbiter: credit-based bus arbiter granting the highest affordable bid with round-robin ties
module bid_arbiter
    import bid_arb_pkg::*;
#(
    parameter int N_MASTERS     = DEF_N_MASTERS,
    parameter int BID_W         = DEF_BID_W,
    parameter int BAL_W         = DEF_BAL_W,
    parameter int BAL_INIT      = DEF_BAL_INIT,
    parameter int BAL_MAX       = DEF_BAL_MAX,
    parameter int REFILL_AMT    = DEF_REFILL_AMT,
    parameter int REFILL_PERIOD = DEF_REFILL_PERIOD,
    parameter int MAX_HOLD      = DEF_MAX_HOLD
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_MASTERS-1:0]         req,
    input  logic [N_MASTERS*BID_W-1:0]   bid,
    output logic [N_MASTERS-1:0]         grant,
    output logic                         grant_valid,
    output logic [$clog2(N_MASTERS)-1:0] grant_id,
    output logic                         hold_expired,
    output logic [N_MASTERS*BAL_W-1:0]   balance
);

    localparam int ID_W = $clog2(N_MASTERS);
    localparam int HC_W = $clog2(MAX_HOLD + 1);
    localparam int RC_W = $clog2(REFILL_PERIOD + 1);

    state_t           state, state_d;
    logic [ID_W-1:0]  w, w_d, rr_ptr, rr_d, win, idx;
    logic [ID_W:0]    scan;
    logic [BID_W-1:0] best;
    logic [BID_W-1:0] bids [N_MASTERS];
    logic [BAL_W-1:0] bals [N_MASTERS];
    logic [N_MASTERS-1:0] eligible, debit_en;
    logic [HC_W-1:0]  hold_cnt, hold_d;
    logic [RC_W-1:0]  refill_cnt;
    logic             refill_pulse, expired_d;

    assign refill_pulse = refill_cnt == RC_W'(REFILL_PERIOD - 1);
    assign grant_valid  = |grant;

    for (genvar g = 0; g < N_MASTERS; g++) begin : g_acct
        assign bids[g]     = bid[g*BID_W +: BID_W];
        assign eligible[g] = req[g] && bids[g] != '0 && bals[g] >= BAL_W'(bids[g]);
        credit_account #(
            .BAL_W      (BAL_W),
            .BAL_INIT   (BAL_INIT),
            .BAL_MAX    (BAL_MAX),
            .REFILL_AMT (REFILL_AMT)
        ) u_acct (
            .clk          (clk),
            .rst_n        (rst_n),
            .debit_en     (debit_en[g]),
            .debit_amt    (BAL_W'(bids[g])),
            .refill_pulse (refill_pulse),
            .balance      (bals[g])
        );
        assign balance[g*BAL_W +: BAL_W] = bals[g];
    end

    // scan from rr_ptr upward; strict > keeps the first tied index in scan order
    always_comb begin
        win  = '0;
        best = '0;
        idx  = '0;
        scan = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
            idx  = (scan >= (ID_W+1)'(N_MASTERS)) ? ID_W'(scan - (ID_W+1)'(N_MASTERS)) : ID_W'(scan);
            if (eligible[idx] && bids[idx] > best) begin
                win  = idx;
                best = bids[idx];
            end
        end
    end

    always_comb begin
        state_d   = state;
        w_d       = w;
        rr_d      = rr_ptr;
        hold_d    = hold_cnt;
        expired_d = 1'b0;
        debit_en  = '0;
        if (state == IDLE) begin
            if (|eligible) begin
                state_d       = GRANT;
                w_d           = win;
                hold_d        = '0;
                rr_d          = (win == ID_W'(N_MASTERS - 1)) ? '0 : win + 1'b1;
                debit_en[win] = 1'b1;
            end
        end else if (!req[w]) begin
            state_d = IDLE;
        end else if (hold_cnt == HC_W'(MAX_HOLD - 1)) begin
            state_d   = IDLE;
            expired_d = 1'b1;
        end else begin
            hold_d = hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            w            <= '0;
            rr_ptr       <= '0;
            hold_cnt     <= '0;
            refill_cnt   <= '0;
            grant        <= '0;
            grant_id     <= '0;
            hold_expired <= 1'b0;
        end else begin
            state        <= state_d;
            w            <= w_d;
            rr_ptr       <= rr_d;
            hold_cnt     <= hold_d;
            refill_cnt   <= refill_pulse ? '0 : refill_cnt + 1'b1;
            grant        <= (state_d == GRANT) ? N_MASTERS'(1) << w_d : '0;
            grant_id     <= (state_d == GRANT) ? w_d : '0;
            hold_expired <= expired_d;
        end
    end

endmodule

// File: tb/tb_bid_arbiter.sv
// tb_bid_arbiter: directed scoreboard bench over three arbiters differing only in BAL_INIT
module tb_bid_arbiter;

    typedef struct packed {
        logic [1:0] dut;
        logic [3:0] grant;
        logic [1:0] id;
        logic       hexp;
        logic [1:0] bidx;
        logic [9:0] bal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_i  [3];
    logic [15:0] bid_i  [3];
    logic [3:0]  grant_o[3];
    logic        gv_o   [3];
    logic [1:0]  id_o   [3];
    logic        he_o   [3];
    logic [39:0] bal_o  [3];

    exp_t  sb[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    string tag = "";

    always #5 clk = ~clk;

    bid_arbiter u0 (
        .clk(clk), .rst_n(rst_n), .req(req_i[0]), .bid(bid_i[0]), .grant(grant_o[0]),
        .grant_valid(gv_o[0]), .grant_id(id_o[0]), .hold_expired(he_o[0]), .balance(bal_o[0])
    );

    bid_arbiter #(.BAL_INIT(10)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req_i[1]), .bid(bid_i[1]), .grant(grant_o[1]),
        .grant_valid(gv_o[1]), .grant_id(id_o[1]), .hold_expired(he_o[1]), .balance(bal_o[1])
    );

    bid_arbiter #(.BAL_INIT(20)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req_i[2]), .bid(bid_i[2]), .grant(grant_o[2]),
        .grant_valid(gv_o[2]), .grant_id(id_o[2]), .hold_expired(he_o[2]), .balance(bal_o[2])
    );

    task automatic push(input int d, input logic [3:0] g, input int id, input logic he, input int bi, input int bal);
        exp_t e;
        e.dut   = 2'(d);
        e.grant = g;
        e.id    = 2'(id);
        e.hexp  = he;
        e.bidx  = 2'(bi);
        e.bal   = 10'(bal);
        sb.push_back(e);
    endtask

    task automatic set_bid(input int d, input int m, input int v);
        bid_i[d][m*4 +: 4] = 4'(v);
    endtask

    task automatic step();
        exp_t e;
        logic [9:0] b;
        @(posedge clk);
        #1;
        if (rst_n) cyc++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            b = bal_o[e.dut][e.bidx*10 +: 10];
            total++;
            assert (grant_o[e.dut] === e.grant) else begin
                bad++;
                $error("FAIL %s grant u%0d: got %b want %b", tag, e.dut, grant_o[e.dut], e.grant);
            end
            total++;
            assert (gv_o[e.dut] === |e.grant) else begin
                bad++;
                $error("FAIL %s grant_valid u%0d: got %b want %b", tag, e.dut, gv_o[e.dut], |e.grant);
            end
            total++;
            assert (id_o[e.dut] === e.id) else begin
                bad++;
                $error("FAIL %s grant_id u%0d: got %0d want %0d", tag, e.dut, id_o[e.dut], e.id);
            end
            total++;
            assert (he_o[e.dut] === e.hexp) else begin
                bad++;
                $error("FAIL %s hold_expired u%0d: got %b want %b", tag, e.dut, he_o[e.dut], e.hexp);
            end
            total++;
            assert (b === e.bal) else begin
                bad++;
                $error("FAIL %s balance[%0d] u%0d: got %0d want %0d", tag, e.bidx, e.dut, b, e.bal);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req_i[d] = '0;
            bid_i[d] = '0;
        end
        tag = "reset";
        step();
        for (int m = 0; m < 4; m++) push(0, 4'b0000, 0, 1'b0, m, 750);
        push(1, 4'b0000, 0, 1'b0, 0, 10);
        push(2, 4'b0000, 0, 1'b0, 0, 20);
        step();
        rst_n = 1'b1;
        cyc = 0;

        tag = "single";
        req_i[0] = 4'b0001;
        set_bid(0, 0, 5);
        push(0, 4'b0001, 0, 1'b0, 0, 745);
        step();
        req_i[0] = 4'b0000;
        push(0, 4'b0000, 0, 1'b0, 0, 745);
        step();

        tag = "tie";
        set_bid(0, 1, 7);
        set_bid(0, 2, 7);
        req_i[0] = 4'b0110;
        push(0, 4'b0010, 1, 1'b0, 1, 743);
        step();
        req_i[0] = 4'b0100;
        push(0, 4'b0000, 0, 1'b0, 1, 743);
        step();
        req_i[0] = 4'b0110;
        push(0, 4'b0100, 2, 1'b0, 2, 743);
        step();
        req_i[0] = 4'b0010;
        push(0, 4'b0000, 0, 1'b0, 2, 743);
        step();
        req_i[0] = 4'b0110;
        push(0, 4'b0010, 1, 1'b0, 1, 736);
        step();
        req_i[0] = 4'b0000;
        push(0, 4'b0000, 0, 1'b0, 1, 736);
        step();

        tag = "hold";
        set_bid(0, 3, 1);
        req_i[0] = 4'b1000;
        for (int i = 0; i < 16; i++) begin
            push(0, 4'b1000, 3, 1'b0, 3, 749);
            step();
        end
        push(0, 4'b0000, 0, 1'b1, 3, 749);
        step();
        push(0, 4'b1000, 3, 1'b0, 3, 748);
        step();
        req_i[0] = 4'b0000;
        push(0, 4'b0000, 0, 1'b0, 3, 748);
        step();

        tag = "afford";
        set_bid(1, 0, 12);
        set_bid(1, 1, 3);
        req_i[1] = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            push(1, 4'b0010, 1, 1'b0, 1, 7 - 3*k);
            step();
            req_i[1] = 4'b0001;
            push(1, 4'b0000, 0, 1'b0, 1, 7 - 3*k);
            step();
            req_i[1] = 4'b0011;
        end
        push(1, 4'b0000, 0, 1'b0, 1, 1);
        push(1, 4'b0000, 0, 1'b0, 0, 10);
        step();
        tag = "no_credit";
        while (cyc < 399) begin
            push(1, 4'b0000, 0, 1'b0, 0, 10);
            step();
        end

        tag = "refill";
        set_bid(2, 0, 15);
        req_i[2] = 4'b0001;
        push(0, 4'b0000, 0, 1'b0, 0, 900);
        push(0, 4'b0000, 0, 1'b0, 3, 900);
        push(1, 4'b0000, 0, 1'b0, 0, 760);
        push(1, 4'b0000, 0, 1'b0, 1, 751);
        push(2, 4'b0001, 0, 1'b0, 0, 755);
        push(2, 4'b0001, 0, 1'b0, 1, 770);
        step();
        push(1, 4'b0001, 0, 1'b0, 0, 748);
        push(2, 4'b0001, 0, 1'b0, 0, 755);
        step();

        tag = "reset_mid";
        set_bid(0, 0, 2);
        req_i[0] = 4'b0001;
        push(0, 4'b0001, 0, 1'b0, 0, 898);
        step();
        rst_n = 1'b0;
        req_i[1] = 4'b0000;
        req_i[2] = 4'b0000;
        for (int m = 0; m < 4; m++) push(0, 4'b0000, 0, 1'b0, m, 750);
        push(1, 4'b0000, 0, 1'b0, 0, 10);
        push(2, 4'b0000, 0, 1'b0, 0, 20);
        step();
        rst_n = 1'b1;
        set_bid(0, 0, 4);
        set_bid(0, 1, 4);
        req_i[0] = 4'b0011;
        push(0, 4'b0001, 0, 1'b0, 0, 746);
        step();
        req_i[0] = 4'b0000;
        push(0, 4'b0000, 0, 1'b0, 0, 746);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
